sram_tdp_be: RTL

//   Single-clock, inferred true-dual-port SRAM with per-byte write enables, a selectable

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_rd_pipe.sv | 37 +++
 rtl/sram_tdp_be.sv | 105 ++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-enabled true-dual-port SRAM.
package sram_pkg;

  localparam logic [23:0] RDW_OLD = "old";
  localparam logic [23:0] RDW_NEW = "new";

  // Widest data word merge_be can handle; callers size-cast in and out.
  localparam int MERGE_W = 1024;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic logic [MERGE_W-1:0] merge_be(input logic [MERGE_W-1:0]   old_w,
                                                  input logic [MERGE_W-1:0]   new_w,
                                                  input logic [MERGE_W/8-1:0] be);
    for (int i = 0; i < MERGE_W/8; i++)
      merge_be[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Per-port read return pipeline: 1 + OUT_REG stages, data held while not valid.
module sram_rd_pipe #(
  parameter int WIDTH   = 32,
  parameter int OUT_REG = 0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata
);
  localparam int STAGES = 1 + OUT_REG;

  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  logic [WIDTH-1:0]  dat_q [1:STAGES];

  assign vld_pipe = {vld_q, in_vld};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 1; s <= STAGES; s++) dat_q[s] <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (in_vld) dat_q[1] <= in_data;
      // Stages only load on a valid beat so the output keeps the last read word.
      for (int s = 2; s <= STAGES; s++)
        if (vld_pipe[s-1]) dat_q[s] <= dat_q[s-1];
    end
  end

  assign rvalid = vld_pipe[STAGES];
  assign rdata  = dat_q[STAGES];

endmodule

// File: rtl/sram_tdp_be.sv
// Inferred true-dual-port SRAM with byte enables, selectable read-during-write
// behaviour, optional output register and a post-reset clear engine.
module sram_tdp_be
  import sram_pkg::*;
#(
  parameter int              WIDTH        = 32,
  parameter int              DEPTH        = 256,
  parameter int              ADDR_WIDTH   = $clog2(DEPTH),
  parameter int              OUT_REG      = 0,
  parameter                  RDW_MODE     = "old",
  parameter bit              CLEAR_ON_RST = 1'b1,
  parameter logic [WIDTH-1:0] CLR_VALUE   = '0
)(
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [WIDTH/8-1:0]    a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_wdata,
  output logic [WIDTH-1:0]      a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [WIDTH/8-1:0]    b_be,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0]      b_wdata,
  output logic [WIDTH-1:0]      b_rdata,
  output logic                  b_rvalid
);
  localparam int                    NB         = WIDTH / 8;
  localparam bit                    RDW_IS_NEW = (RDW_MODE == RDW_NEW);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

  if (WIDTH % 8 != 0) begin : g_bad_width
    $error("sram_tdp_be: WIDTH must be a multiple of 8");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
    $error("sram_tdp_be: RDW_MODE must be \"old\" or \"new\"");
  end

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [WIDTH-1:0]        mem [DEPTH];

  logic             ready, clr_wr;
  logic             a_inr, b_inr, a_wr, b_wr, b_hit, a_rv, b_rv;
  logic [WIDTH-1:0] a_old, b_old, a_word, b_word, b_view, a_rd, b_rd;

  assign ready  = (state == ST_READY) && !rst;
  assign clr_wr = (state == ST_CLEAR) && !rst;

  assign a_inr = int'(a_addr) < DEPTH;
  assign b_inr = int'(b_addr) < DEPTH;
  assign a_old = a_inr ? mem[a_addr] : '0;
  assign b_old = b_inr ? mem[b_addr] : '0;

  assign a_wr  = ready && a_en && a_we && (|a_be) && a_inr;
  assign b_wr  = ready && b_en && b_we && (|b_be) && b_inr;
  assign b_hit = a_wr && b_wr && (a_addr == b_addr);

  // On an address collision A's bytes are layered over B's merged word.
  assign b_word = WIDTH'(merge_be(MERGE_W'(b_old), MERGE_W'(b_wdata), (MERGE_W/8)'(b_be)));
  assign a_word = WIDTH'(merge_be(MERGE_W'(b_hit ? b_word : a_old), MERGE_W'(a_wdata),
                                  (MERGE_W/8)'(a_be)));
  assign b_view = b_hit ? a_word : b_word;

  assign a_rv = ready && a_en && (!a_we || (|a_be));
  assign b_rv = ready && b_en && (!b_we || (|b_be));
  assign a_rd = !a_inr ? '0 : (a_we && RDW_IS_NEW) ? a_word : a_old;
  assign b_rd = !b_inr ? '0 : (b_we && RDW_IS_NEW) ? b_view : b_old;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
      clr_cnt   <= '0;
      init_busy <= CLEAR_ON_RST;
    end else if (state == ST_CLEAR) begin
      if (clr_cnt == LAST_ADDR) begin
        state     <= ST_READY;
        init_busy <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_cnt] <= CLR_VALUE;
    end else begin
      if (b_wr && !b_hit) mem[b_addr] <= b_word;
      if (a_wr)           mem[a_addr] <= a_word;
    end
  end

  sram_rd_pipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk(clk), .rst(rst), .in_vld(a_rv), .in_data(a_rd), .rvalid(a_rvalid), .rdata(a_rdata)
  );
  sram_rd_pipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk(clk), .rst(rst), .in_vld(b_rv), .in_data(b_rd), .rvalid(b_rvalid), .rdata(b_rdata)
  );

endmodule
